mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of both requesters and the RAM port.
REQ-002 Parameter DATA_W, default 32: data width of both requesters and the RAM port.
REQ-003 Parameter STARVE_MAX, default 3: number of consecutive data-port wins after which a pending fetch is forced through.
REQ-004 Parameter TIMEOUT, default 15: maximum RAM wait cycles before an access is aborted.
REQ-005 Ports clk and rst_n: one clock; reset is asynchronous and active-low.
  - clk, input, 1: rising-edge clock.
  - rst_n, input, 1: asynchronous active-low reset.
REQ-006 Fetch port:
  - if_req, input, 1: instruction fetch request.
  - if_addr, input, ADDR_W: fetch address.
  - if_gnt, output, 1: fetch access in progress.
  - if_done, output, 1: one-cycle completion pulse.
  - if_rdata, output, DATA_W: fetched word.
REQ-007 Data port:
  - d_req, input, 1: data access request.
  - d_we, input, 1: 1 = store.
  - d_be, input, 4: byte enables.
  - d_addr, input, ADDR_W: data address.
  - d_wdata, input, DATA_W: store data.
  - d_gnt, output, 1: data access in progress.
  - d_done, output, 1: one-cycle completion pulse.
  - d_rdata, output, DATA_W: load data.
REQ-008 RAM port:
  - ram_en, output, 1: access strobe.
  - ram_we, output, 1: write strobe.
  - ram_be, output, 4: byte enables.
  - ram_addr, output, ADDR_W: access address.
  - ram_wdata, output, DATA_W: write data.
  - ram_rdata, input, DATA_W: read data.
  - ram_ready, input, 1: access complete.
REQ-009 Status outputs:
  - busy, output, 1: FSM not in IDLE.
  - err, output, 1: sticky timeout flag.

Function
REQ-010 The FSM SHALL have three states: IDLE, IF_ACC and D_ACC, encoded as registered state.
REQ-011 In IDLE at a rising edge, the arbiter SHALL decide as follows:
  - d_req only -> D_ACC.
  - if_req only -> IF_ACC.
  - both -> D_ACC, unless starve_cnt == STARVE_MAX, in which case -> IF_ACC.
  - neither -> stay in IDLE.
REQ-012 starve_cnt SHALL behave as follows:
  - increments on each D_ACC entry while if_req is high.
  - clears on each IF_ACC entry.
  - saturates at STARVE_MAX.
REQ-013 On entering an access state, the arbiter SHALL latch the address, we, be and wdata of the winning requester; requester inputs SHALL be ignored until the access returns to IDLE.
REQ-014 IF_ACC SHALL drive ram_we = 0 and ram_be = 4'b1111.
REQ-015 While in IF_ACC or D_ACC, the arbiter SHALL drive the following from latched values, with all RAM outputs 0 in IDLE:
  - ram_en = 1.
  - the matching gnt = 1.
REQ-016 Latency from request sampled in IDLE to ram_en high SHALL be exactly 1 cycle.
REQ-017 When ram_ready is sampled high in an access state:
  - the FSM SHALL return to IDLE.
  - on the next cycle the matching done SHALL pulse high for exactly 1 cycle.
  - the matching rdata SHALL be registered from ram_rdata, with d_rdata loaded only for loads.
REQ-018 The rdata outputs SHALL hold their last value until the next completion on the same port.
REQ-019 A requester SHALL hold req high until its done pulse; a req still high in the done cycle SHALL be treated as a new request.
REQ-020 wait_cnt SHALL behave as follows:
  - clears on access entry.
  - increments each access cycle with ram_ready low.
REQ-021 If wait_cnt reaches TIMEOUT with ram_ready low:
  - the FSM SHALL return to IDLE.
  - the matching done SHALL pulse.
  - rdata SHALL be left unchanged.
  - err SHALL set and hold until reset.
REQ-022 ram_ready SHALL be ignored while in IDLE.
REQ-023 If ram_ready arrives in the same cycle that wait_cnt reaches TIMEOUT, the arbiter SHALL complete normally, with no error.
REQ-024 At most one of if_gnt and d_gnt SHALL be high, and at most one of if_done and d_done SHALL be high, in any cycle.

Reset
REQ-025 On rst_n low, the block SHALL asynchronously force:
  - state = IDLE.
  - all outputs, if_rdata, d_rdata, starve_cnt, wait_cnt and err = 0.
REQ-026 Reset asserted mid-access SHALL abort the access without a done pulse; the first arbitration SHALL occur at the first rising edge after rst_n is high.

Verification
REQ-027 Fetch-only test: if_req with if_addr = 0x0040_0000, and RAM returning 0x2408_0005 with ready 2 cycles after ram_en -> the bench SHALL see:
  - ram_en for 3 cycles with ram_we = 0.
  - if_done for 1 cycle.
  - if_rdata = 0x2408_0005.
REQ-028 Simultaneous-request test: if_req and d_req both high, d_we = 1, d_be = 4'b0011, d_wdata = 0xDEAD_BEEF -> the bench SHALL see D_ACC first with ram_we = 1, ram_be = 4'b0011, then IF_ACC.
REQ-029 Starvation test: d_req and if_req held high continuously, STARVE_MAX = 3 -> the bench SHALL see exactly 3 data accesses, then 1 fetch access, repeating.
REQ-030 Timeout test: ram_ready held low -> the bench SHALL see:
  - d_done pulse 17 cycles after the request edge (1 cycle of grant latency, TIMEOUT + 1 = 16 wait cycles of ram_en high, then the registered done).
  - err = 1.
  - d_rdata unchanged.
REQ-031 Ready-at-limit test: ram_ready arriving in the cycle wait_cnt reaches 15 -> the bench SHALL see normal completion with err = 0.
REQ-032 Reset-mid-access test: rst_n pulsed low during D_ACC -> the bench SHALL see all outputs 0 immediately, no d_done pulse, and clean arbitration after release.

Source files
------------

// File: rtl/mem_port_if.sv
// Bundled fetch, data and RAM signals of the memory-port arbiter.
// The arbiter connects through slave; the requesters and RAM model connect through master.
interface mem_port_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ready;

  logic              busy;
  logic              err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata, ram_ready,
    output if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
           ram_en, ram_we, ram_be, ram_addr, ram_wdata, busy, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata, ram_ready,
    input  if_gnt, if_done, if_rdata, d_gnt, d_done, d_rdata,
           ram_en, ram_we, ram_be, ram_addr, ram_wdata, busy, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single RAM port with data priority,
// fetch anti-starvation, RAM-wait timeout and registered completion pulses.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_port_if.slave   bus
);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [WW-1:0] WAIT_LIM   = WW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, IF_ACC = 2'd1, D_ACC = 2'd2} state_t;

  state_t            state, state_d;
  logic [SW-1:0]     starve_cnt;
  logic [WW-1:0]     wait_cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [3:0]        lat_be;
  logic [DATA_W-1:0] lat_wdata;
  logic              if_done_q, d_done_q, err_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  logic in_acc, acc_ok, acc_abort, acc_end;
  logic enter_if, enter_d;

  assign in_acc    = (state != IDLE);
  assign acc_ok    = in_acc && bus.ram_ready;
  // ready in the limit cycle wins over the timeout
  assign acc_abort = in_acc && !bus.ram_ready && (wait_cnt == WAIT_LIM);
  assign acc_end   = acc_ok || acc_abort;
  assign enter_if  = (state == IDLE) && (state_d == IF_ACC);
  assign enter_d   = (state == IDLE) && (state_d == D_ACC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (bus.d_req && bus.if_req)
          state_d = (starve_cnt == STARVE_LIM) ? IF_ACC : D_ACC;
        else if (bus.d_req)
          state_d = D_ACC;
        else if (bus.if_req)
          state_d = IF_ACC;
      end
      IF_ACC, D_ACC: if (acc_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access qualifiers are captured once; requester inputs are don't-care until IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_be    <= 4'b0000;
      lat_wdata <= '0;
    end else if (enter_d) begin
      lat_addr  <= bus.d_addr;
      lat_we    <= bus.d_we;
      lat_be    <= bus.d_be;
      lat_wdata <= bus.d_wdata;
    end else if (enter_if) begin
      lat_addr  <= bus.if_addr;
      lat_we    <= 1'b0;
      lat_be    <= 4'b1111;
      lat_wdata <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      if (enter_if)
        starve_cnt <= '0;
      else if (enter_d && bus.if_req && (starve_cnt != STARVE_LIM))
        starve_cnt <= starve_cnt + 1'b1;

      if (!in_acc)
        wait_cnt <= '0;
      else if (!bus.ram_ready && (wait_cnt != WAIT_LIM))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      if_done_q <= (state == IF_ACC) && acc_end;
      d_done_q  <= (state == D_ACC) && acc_end;
      if ((state == IF_ACC) && acc_ok)
        if_rdata_q <= bus.ram_rdata;
      if ((state == D_ACC) && acc_ok && !lat_we)
        d_rdata_q <= bus.ram_rdata;
      if (acc_abort)
        err_q <= 1'b1;
    end
  end

  assign bus.ram_en    = in_acc;
  assign bus.ram_we    = (state == D_ACC) && lat_we;
  assign bus.ram_be    = in_acc ? lat_be : 4'b0000;
  assign bus.ram_addr  = in_acc ? lat_addr : '0;
  assign bus.ram_wdata = (state == D_ACC) ? lat_wdata : '0;

  assign bus.if_gnt    = (state == IF_ACC);
  assign bus.d_gnt     = (state == D_ACC);
  assign bus.if_done   = if_done_q;
  assign bus.d_done    = d_done_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = in_acc;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  mem_port_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(3), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [145:0] outs;
    rst_n = 1'b0;
    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_be = '0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.ram_rdata = '0; bus.ram_ready = 0;
    repeat (2) cyc();
    outs = {bus.ram_en, bus.ram_we, bus.ram_be, bus.ram_addr, bus.ram_wdata, bus.if_gnt,
            bus.d_gnt, bus.if_done, bus.d_done, bus.if_rdata, bus.d_rdata, bus.busy, bus.err};
    n_chk++;
    if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h want=0", outs); end
    rst_n = 1'b1;
    bus.ram_ready = 1'b1;  // ignored in IDLE
    cyc();
    n_chk++;
    if ({bus.busy, bus.ram_en, bus.if_done, bus.d_done} !== 4'b0) begin
      n_fail++; $display("FAIL reset_idle got=%b want=0000", {bus.busy, bus.ram_en, bus.if_done, bus.d_done});
    end
    bus.ram_ready = 1'b0;
  endtask

  task automatic test_fetch();
    bus.if_req = 1; bus.if_addr = 32'h0040_0000;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      n_chk++;
      if ({bus.ram_en, bus.ram_we, bus.ram_be, bus.if_gnt, bus.d_gnt, bus.if_done} !== 9'b1_0_1111_1_0_0 ||
          bus.ram_addr !== 32'h0040_0000) begin
        n_fail++; $display("FAIL fetch_access cyc=%0d en=%b we=%b be=%b gnt=%b addr=%h want en=1 we=0 be=1111 if_gnt=1 addr=00400000",
                           k, bus.ram_en, bus.ram_we, bus.ram_be, bus.if_gnt, bus.ram_addr);
      end
      if (k == 3) begin bus.ram_ready = 1; bus.ram_rdata = 32'h2408_0005; end
    end
    cyc();
    n_chk++;
    if ({bus.ram_en, bus.if_done, bus.d_done} !== 3'b010 || bus.if_rdata !== 32'h2408_0005) begin
      n_fail++; $display("FAIL fetch_done en=%b if_done=%b d_done=%b rdata=%h want 0 1 0 24080005",
                         bus.ram_en, bus.if_done, bus.d_done, bus.if_rdata);
    end
    bus.if_req = 0; bus.ram_ready = 0; bus.ram_rdata = 32'hFFFF_0000;
    cyc();
    n_chk++;
    if ({bus.if_done, bus.busy} !== 2'b00 || bus.if_rdata !== 32'h2408_0005) begin
      n_fail++; $display("FAIL fetch_hold done=%b busy=%b rdata=%h want 0 0 24080005", bus.if_done, bus.busy, bus.if_rdata);
    end
  endtask

  task automatic test_simultaneous();
    bus.if_req = 1; bus.if_addr = 32'h0000_0100;
    bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011; bus.d_addr = 32'h0000_0200; bus.d_wdata = 32'hDEAD_BEEF;
    cyc();
    n_chk++;
    if ({bus.d_gnt, bus.if_gnt, bus.ram_we, bus.ram_be} !== 7'b1_0_1_0011 ||
        bus.ram_wdata !== 32'hDEAD_BEEF || bus.ram_addr !== 32'h0000_0200) begin
      n_fail++; $display("FAIL simul_data_first d_gnt=%b if_gnt=%b we=%b be=%b wdata=%h addr=%h want 1 0 1 0011 deadbeef 00000200",
                         bus.d_gnt, bus.if_gnt, bus.ram_we, bus.ram_be, bus.ram_wdata, bus.ram_addr);
    end
    bus.ram_ready = 1; bus.ram_rdata = 32'h1111_2222;
    cyc();
    n_chk++;
    if ({bus.d_done, bus.if_done} !== 2'b10) begin
      n_fail++; $display("FAIL simul_store_done d_done=%b if_done=%b want 1 0", bus.d_done, bus.if_done);
    end
    bus.d_req = 0; bus.d_we = 0; bus.ram_ready = 0;
    cyc();
    n_chk++;
    if ({bus.if_gnt, bus.d_gnt, bus.ram_we, bus.ram_be} !== 7'b1_0_0_1111 || bus.ram_addr !== 32'h0000_0100 ||
        bus.d_rdata !== 32'h0) begin
      n_fail++; $display("FAIL simul_fetch_second if_gnt=%b d_gnt=%b we=%b be=%b addr=%h d_rdata=%h want 1 0 0 1111 00000100 0",
                         bus.if_gnt, bus.d_gnt, bus.ram_we, bus.ram_be, bus.ram_addr, bus.d_rdata);
    end
    bus.ram_ready = 1; bus.ram_rdata = 32'h3333_4444;
    cyc();
    n_chk++;
    if ({bus.if_done, bus.d_done} !== 2'b10 || bus.if_rdata !== 32'h3333_4444) begin
      n_fail++; $display("FAIL simul_fetch_done if_done=%b rdata=%h want 1 33334444", bus.if_done, bus.if_rdata);
    end
    bus.if_req = 0; bus.ram_ready = 0;
    cyc();
  endtask

  task automatic test_starvation();
    int n_d, n_if;
    logic [1:0] exp_gnt;
    n_d = 0; n_if = 0;
    bus.if_req = 1; bus.if_addr = 32'h0000_0500;
    bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'b1111; bus.d_addr = 32'h0000_0600;
    bus.ram_ready = 1; bus.ram_rdata = 32'h5555_AAAA;
    // Each access takes one cycle then one IDLE cycle; every fourth access is the fetch.
    for (int k = 1; k <= 16; k++) begin
      cyc();
      if (k % 2 == 0)                 exp_gnt = 2'b00;
      else if (((k - 1) / 2) % 4 == 3) exp_gnt = 2'b10;
      else                            exp_gnt = 2'b01;
      n_chk++;
      if ({bus.if_gnt, bus.d_gnt} !== exp_gnt) begin
        n_fail++; $display("FAIL starve_pattern cyc=%0d {if_gnt,d_gnt}=%b want %b", k, {bus.if_gnt, bus.d_gnt}, exp_gnt);
      end
      if (bus.d_gnt === 1'b1) n_d++;
      if (bus.if_gnt === 1'b1) n_if++;
    end
    n_chk++;
    if (n_d != 6 || n_if != 2 || bus.d_rdata !== 32'h5555_AAAA) begin
      n_fail++; $display("FAIL starve_totals data=%0d fetch=%0d d_rdata=%h want 6 2 5555aaaa", n_d, n_if, bus.d_rdata);
    end
    bus.if_req = 0; bus.d_req = 0; bus.ram_ready = 0;
    cyc();
  endtask

  task automatic test_ready_at_limit();
    int n_en;
    n_en = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h0000_0400;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      if (bus.ram_en === 1'b1 && bus.d_done === 1'b0) n_en++;
      if (k == 16) begin bus.ram_ready = 1; bus.ram_rdata = 32'h1234_5678; end
    end
    n_chk++;
    if (n_en != 16) begin n_fail++; $display("FAIL limit_wait en_cycles=%0d want 16", n_en); end
    cyc();
    n_chk++;
    if ({bus.d_done, bus.err, bus.ram_en} !== 3'b100 || bus.d_rdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL limit_complete d_done=%b err=%b en=%b rdata=%h want 1 0 0 12345678",
                         bus.d_done, bus.err, bus.ram_en, bus.d_rdata);
    end
    bus.d_req = 0; bus.ram_ready = 0;
    cyc();
  endtask

  task automatic test_timeout();
    int n_en;
    n_en = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h0000_0300; bus.ram_rdata = 32'hBAD0_BAD0;
    for (int k = 1; k <= 16; k++) begin
      cyc();
      if (bus.ram_en === 1'b1 && bus.d_done === 1'b0) n_en++;
    end
    n_chk++;
    if (n_en != 16) begin n_fail++; $display("FAIL timeout_wait en_cycles=%0d want 16", n_en); end
    cyc();
    n_chk++;
    if ({bus.d_done, bus.err, bus.ram_en} !== 3'b110 || bus.d_rdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL timeout_abort d_done=%b err=%b en=%b rdata=%h want 1 1 0 12345678",
                         bus.d_done, bus.err, bus.ram_en, bus.d_rdata);
    end
    bus.d_req = 0;
    repeat (2) cyc();
    n_chk++;
    if ({bus.d_done, bus.err} !== 2'b01) begin
      n_fail++; $display("FAIL timeout_sticky d_done=%b err=%b want 0 1", bus.d_done, bus.err);
    end
  endtask

  task automatic test_reset_mid_access();
    bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b1100; bus.d_addr = 32'h0000_0700; bus.d_wdata = 32'hCAFE_F00D;
    cyc();
    n_chk++;
    if (bus.d_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_enter d_gnt=%b want 1", bus.d_gnt); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.ram_en, bus.ram_we, bus.ram_be, bus.d_gnt, bus.d_done, bus.busy, bus.err} !== 10'b0 ||
        bus.ram_addr !== '0 || bus.d_rdata !== '0 || bus.if_rdata !== '0) begin
      n_fail++; $display("FAIL rstmid_async en=%b gnt=%b busy=%b err=%b addr=%h d_rdata=%h if_rdata=%h want all 0",
                         bus.ram_en, bus.d_gnt, bus.busy, bus.err, bus.ram_addr, bus.d_rdata, bus.if_rdata);
    end
    bus.ram_ready = 1;
    repeat (2) cyc();
    n_chk++;
    if ({bus.d_done, bus.busy} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_no_done d_done=%b busy=%b want 0 0", bus.d_done, bus.busy);
    end
    bus.ram_ready = 0;
    rst_n = 1'b1;
    cyc();
    n_chk++;
    if ({bus.d_gnt, bus.ram_we, bus.ram_be, bus.d_done} !== 7'b1_1_1100_0 || bus.ram_wdata !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL rstmid_rearb d_gnt=%b we=%b be=%b done=%b wdata=%h want 1 1 1100 0 cafef00d",
                         bus.d_gnt, bus.ram_we, bus.ram_be, bus.d_done, bus.ram_wdata);
    end
    bus.ram_ready = 1;
    cyc();
    n_chk++;
    if ({bus.d_done, bus.err} !== 2'b10) begin
      n_fail++; $display("FAIL rstmid_complete d_done=%b err=%b want 1 0", bus.d_done, bus.err);
    end
    bus.d_req = 0; bus.ram_ready = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_ready_at_limit();
    test_timeout();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_chk++;
      if ((bus.if_gnt && bus.d_gnt) || (bus.if_done && bus.d_done)) begin
        n_fail++; $display("FAIL mutex gnt=%b%b done=%b%b want at most one high",
                           bus.if_gnt, bus.d_gnt, bus.if_done, bus.d_done);
      end
    end
  end
endmodule
